// File: rtl/universal_shift_register.sv
// universal_shift_register
//   Parametrised universal shift register with hold / shift right / shift left /
//   parallel load, plus an autonomous burst engine that performs up to WIDTH
//   shifts after a single start pulse.
//
//   Optional feature macro: USR_ROTATE_EN (adds the 'rotate' input; when set the
//   shift-in bit is the wrapped bit instead of the serial input).
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   enable           qualifies a manual operation while idle
//   mode             00 hold, 01 shift right, 10 shift left, 11 parallel load
//   serial_in_left   bit entering at the MSB on a right shift
//   serial_in_right  bit entering at the LSB on a left shift
//   parallel_in      load data
//   start            one-cycle pulse launching a burst
//   dir              burst direction (0 right, 1 left), captured on start
//   count            number of burst shifts (saturates at WIDTH), captured on start
//   rotate           (USR_ROTATE_EN only) wrap instead of taking serial input
//   parallel_out     register contents
//   serial_out_right q[0], taken straight from the register
//   serial_out_left  q[WIDTH-1], taken straight from the register
//   busy             burst in progress
//   done             one-cycle pulse on burst completion (also for count=0)

module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
`ifdef USR_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_right,
  output logic             serial_out_left,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             bdir, bdir_n;
  logic             brot, brot_n;
  logic             busy_n;
  logic             done_n;

  logic [CNT_W-1:0] count_sat;
  logic             rot_live;

  // Live rotate request; tied off when the feature is not built.
`ifdef USR_ROTATE_EN
  assign rot_live = rotate;
`else
  assign rot_live = 1'b0;
`endif

  // Requests longer than the register collapse to one full pass.
  assign count_sat = (count > CNT_MAX) ? CNT_MAX : count;

  // Right shift: new MSB is either the serial input or the wrapped LSB.
  function automatic logic [WIDTH-1:0] shift_right(
    input logic [WIDTH-1:0] v,
    input logic             sin,
    input logic             rot
  );
    logic b;
    b = rot ? v[0] : sin;
    return {b, v[WIDTH-1:1]};
  endfunction

  // Left shift: new LSB is either the serial input or the wrapped MSB.
  function automatic logic [WIDTH-1:0] shift_left(
    input logic [WIDTH-1:0] v,
    input logic             sin,
    input logic             rot
  );
    logic b;
    b = rot ? v[WIDTH-1] : sin;
    return {v[WIDTH-2:0], b};
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      bdir  <= 1'b0;
      brot  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      cnt   <= cnt_n;
      bdir  <= bdir_n;
      brot  <= brot_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    q_n     = q;
    cnt_n   = cnt;
    bdir_n  = bdir;
    brot_n  = brot;
    busy_n  = busy;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          // A start always wins over a manual operation in the same cycle.
          if (count_sat == CNT_ZERO) begin
            done_n = 1'b1;
          end else begin
            state_n = SHIFT;
            cnt_n   = count_sat;
            bdir_n  = dir;
            brot_n  = rot_live;
            busy_n  = 1'b1;
          end
        end else if (enable) begin
          unique case (mode)
            MODE_HOLD:  q_n = q;
            MODE_RIGHT: q_n = shift_right(q, serial_in_left, rot_live);
            MODE_LEFT:  q_n = shift_left(q, serial_in_right, rot_live);
            MODE_LOAD:  q_n = parallel_in;
            default:    q_n = q;
          endcase
        end
      end

      SHIFT: begin
        // Serial inputs are sampled live; direction and rotate were latched.
        q_n   = bdir ? shift_left(q, serial_in_right, brot)
                     : shift_right(q, serial_in_left, brot);
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign parallel_out     = q;
  assign serial_out_right = q[0];
  assign serial_out_left  = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);
`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    mode;
  logic          serial_in_left;
  logic          serial_in_right;
  logic [W-1:0]  parallel_in;
  logic          start;
  logic          dir;
  logic [CW-1:0] count;
  logic          rotate;
  logic [W-1:0]  parallel_out;
  logic          serial_out_right;
  logic          serial_out_left;
  logic          busy;
  logic          done;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .mode             (mode),
    .serial_in_left   (serial_in_left),
    .serial_in_right  (serial_in_right),
    .parallel_in      (parallel_in),
    .start            (start),
    .dir              (dir),
    .count            (count),
`ifdef USR_ROTATE_EN
    .rotate           (rotate),
`endif
    .parallel_out     (parallel_out),
    .serial_out_right (serial_out_right),
    .serial_out_left  (serial_out_left),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: register value, shifts still owed, latched burst settings.
  logic [W-1:0] mq;
  int           rem;
  logic         mdir;
  logic         mrot;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  function automatic logic [W-1:0] model_shift(input logic [W-1:0] v, input logic left,
                                               input logic sin, input logic rot);
    int unsigned x;
    int unsigned b;
    x = int'(v);
    if (!left) begin
      b = rot ? (x % 2) : int'(sin);
      return W'((x / 2) + b * (1 << (W - 1)));
    end else begin
      b = rot ? (x / (1 << (W - 1))) : int'(sin);
      return W'(((x * 2) % (1 << W)) + b);
    end
  endfunction

  // Drive one cycle of stimulus and record what the next edge must produce.
  task automatic cycle(input logic en, input logic [1:0] md, input logic sil, input logic sir,
                       input logic [W-1:0] pin, input logic st, input logic dr,
                       input logic [CW-1:0] cnt, input logic rot);
    int   n;
    logic d;
    exp_t e;
    @(negedge clk);
    enable = en; mode = md; serial_in_left = sil; serial_in_right = sir;
    parallel_in = pin; start = st; dir = dr; count = cnt; rotate = rot;
    d = 1'b0;
    if (rem > 0) begin
      mq  = model_shift(mq, mdir, mdir ? sir : sil, mrot);
      rem = rem - 1;
      if (rem == 0) d = 1'b1;
    end else if (st) begin
      n = (int'(cnt) > int'(W)) ? int'(W) : int'(cnt);
      if (n == 0) d = 1'b1;
      else begin
        rem = n; mdir = dr; mrot = rot & ROT_EN;
      end
    end else if (en) begin
      case (md)
        2'b01:   mq = model_shift(mq, 1'b0, sil, rot & ROT_EN);
        2'b10:   mq = model_shift(mq, 1'b1, sir, rot & ROT_EN);
        2'b11:   mq = pin;
        default: mq = mq;
      endcase
    end
    e.q = mq; e.busy = (rem != 0); e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [W-1:0] v);
    cycle(1'b1, 2'b11, 1'b0, 1'b0, v, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic burst(input logic dr, input logic [CW-1:0] cnt, input logic sin, input logic rot);
    cycle(1'b0, 2'b00, sin, sin, '0, 1'b1, dr, cnt, rot);
  endtask

  // Directly check the register a moment after the edge of the last cycle.
  task automatic expect_q(input string name, input logic [W-1:0] v);
    @(posedge clk);
    #2;
    chk(name, 32'(parallel_out), 32'(v));
  endtask

  // Asynchronous reset between edges, checked before any clock edge occurs.
  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk({name, "_q"},    32'(parallel_out), 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
    chk({name, "_done"}, 32'(done), 32'h0);
    chk({name, "_sor"},  32'(serial_out_right), 32'h0);
    chk({name, "_sol"},  32'(serial_out_left), 32'h0);
    enable = 1'b0; start = 1'b0; mode = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mq = '0; rem = 0; mdir = 1'b0; mrot = 1'b0;
  endtask

  // Monitor: every edge with a pending expectation is compared against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q",    32'(parallel_out), 32'(e.q));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("sor",  32'(serial_out_right), 32'(e.q[0]));
        chk("sol",  32'(serial_out_left), 32'(e.q[W-1]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; enable = 1'b0; mode = 2'b00; serial_in_left = 1'b0;
    serial_in_right = 1'b0; parallel_in = '0; start = 1'b0; dir = 1'b0;
    count = '0; rotate = 1'b0;
    mq = '0; rem = 0; mdir = 1'b0; mrot = 1'b0;
    do_reset("por");
    idle(2);

    // Manual operations
    load(8'hA5);                       expect_q("load", 8'hA5);
    cycle(1'b1, 2'b01, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0); expect_q("shr", 8'hD2);
    load(8'hA5);
    cycle(1'b1, 2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0); expect_q("shl", 8'h4A);
    cycle(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, '0, 1'b0); expect_q("en0", 8'h4A);

    // Left burst of 3 with mode/enable toggling while busy
    load(8'h81);
    burst(1'b1, CW'(3), 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 2'b01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, CW'(5), 1'b0);
    cycle(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, '0, 1'b0);
    expect_q("burst3", 8'h08);
    idle(2);

    // Zero-length and saturating bursts
    burst(1'b0, CW'(0), 1'b0, 1'b0);
    idle(2);
    load(8'h5A);
    burst(1'b0, CW'(15), 1'b0, 1'b0);
    idle(8);
    expect_q("sat15", 8'h00);
    idle(2);

    // Back-to-back: second start lands on the done cycle
    load(8'h0F);
    burst(1'b1, CW'(2), 1'b1, 1'b0);
    idle(2);
    burst(1'b0, CW'(2), 1'b0, 1'b0);
    idle(4);

    // Reset in the middle of a burst: no done pulse afterwards
    load(8'hFF);
    burst(1'b0, CW'(8), 1'b0, 1'b0);
    idle(3);
    do_reset("midburst");
    idle(3);

    // Rotation (feature builds only)
    if (ROT_EN) begin
      load(8'h81);
      burst(1'b0, CW'(1), 1'b0, 1'b1);
      idle(1);
      expect_q("rot1", 8'hC0);
      burst(1'b0, CW'(8), 1'b0, 1'b1);
      idle(8);
      expect_q("rot8", 8'hC0);
      cycle(1'b1, 2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      idle(2);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), W'($urandom),
            ($urandom_range(0, 7) == 0), 1'($urandom), CW'($urandom_range(0, 15)),
            1'($urandom));
    end
    idle(12);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
